// File: rtl/cond_flag_unit.sv
// cond_flag_unit
// Consumer end of the ALU flag interface. Holds the architectural NZCV
// register, evaluates the instruction condition field against it, gates
// the PC/register/memory write enables and keeps executed/squashed
// instruction counters for performance measurement.
module cond_flag_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Valid,
    input  logic             Stall,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             CntClr,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             C_out,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    // Architectural state
    logic [3:0]       flags_reg;
    logic [3:0]       flags_next;
    logic [CNT_W-1:0] exec_cnt_reg;
    logic [CNT_W-1:0] exec_cnt_next;
    logic [CNT_W-1:0] squash_cnt_reg;
    logic [CNT_W-1:0] squash_cnt_next;

    // Decoded views of the registered flags
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    // Condition evaluation: the eight base predicates, each paired with
    // its complement on odd encodings (AL/NV fall out as 1 / ~1).
    logic [7:0]  base_cond;
    logic [15:0] cond_table;

    // Update enable: a live instruction that is not held and not in reset
    logic go;

    assign flag_n = flags_reg[3];
    assign flag_z = flags_reg[2];
    assign flag_c = flags_reg[1];
    assign flag_v = flags_reg[0];

    // Base predicates; index = Cond[3:1]
    always_comb begin
        base_cond    = 8'b0;
        base_cond[0] = flag_z;                               // EQ / NE
        base_cond[1] = flag_c;                               // CS / CC
        base_cond[2] = flag_n;                               // MI / PL
        base_cond[3] = flag_v;                               // VS / VC
        base_cond[4] = flag_c & ~flag_z;                     // HI / LS
        base_cond[5] = ~(flag_n ^ flag_v);                   // GE / LT
        base_cond[6] = ~flag_z & ~(flag_n ^ flag_v);         // GT / LE
        base_cond[7] = 1'b1;                                 // AL / NV
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_cond
            if ((gi % 2) == 1) begin : g_inv
                assign cond_table[gi] = ~base_cond[gi/2];
            end else begin : g_pos
                assign cond_table[gi] = base_cond[gi/2];
            end
        end
    endgenerate

    // Condition result and gated write enables; CondEx never looks at ALUFlags
    always_comb begin
        go       = Valid & ~Stall & Reset_n;
        CondEx   = cond_table[Cond];
        PCSrc    = PCS & CondEx & go;
        RegWrite = RegW & ~NoWrite & CondEx & go;
        MemWrite = MemW & CondEx & go;
    end

    // Next flags: each pair written independently, only by a passing instruction
    always_comb begin
        flags_next = flags_reg;
        if (go && CondEx) begin
            if (FlagW[1]) begin
                flags_next[3:2] = ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                flags_next[1:0] = ALUFlags[1:0];
            end
        end
    end

    // Next counter values; an explicit clear beats a same-cycle increment
    always_comb begin
        exec_cnt_next   = exec_cnt_reg;
        squash_cnt_next = squash_cnt_reg;
        if (CntClr) begin
            exec_cnt_next   = '0;
            squash_cnt_next = '0;
        end else if (go) begin
            if (CondEx) begin
                exec_cnt_next = exec_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                squash_cnt_next = squash_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            flags_reg      <= 4'b0000;
            exec_cnt_reg   <= '0;
            squash_cnt_reg <= '0;
        end else begin
            flags_reg      <= flags_next;
            exec_cnt_reg   <= exec_cnt_next;
            squash_cnt_reg <= squash_cnt_next;
        end
    end

    assign Flags       = flags_reg;
    assign C_out       = flags_reg[1];
    assign ExecCount   = exec_cnt_reg;
    assign SquashCount = squash_cnt_reg;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Testbench for cond_flag_unit: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the flag register and counters.
module tb_cond_flag_unit;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MOD  = 16;

    logic                CLK;
    logic                Reset_n;
    logic                Valid;
    logic                Stall;
    logic [3:0]          Cond;
    logic [3:0]          ALUFlags;
    logic [1:0]          FlagW;
    logic                PCS;
    logic                RegW;
    logic                MemW;
    logic                NoWrite;
    logic                CntClr;
    logic                CondEx;
    logic                PCSrc;
    logic                RegWrite;
    logic                MemWrite;
    logic [3:0]          Flags;
    logic                C_out;
    logic [TB_CNT_W-1:0] ExecCount;
    logic [TB_CNT_W-1:0] SquashCount;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_n, m_z, m_c, m_v;
    int m_exec, m_squash;

    cond_flag_unit #(.CNT_W(TB_CNT_W)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Valid(Valid), .Stall(Stall),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS),
        .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .CntClr(CntClr),
        .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Flags(Flags), .C_out(C_out),
        .ExecCount(ExecCount), .SquashCount(SquashCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Condition table written out case by case
    function automatic bit model_cond(logic [3:0] cc);
        case (cc)
            4'd0:  return m_z;
            4'd1:  return !m_z;
            4'd2:  return m_c;
            4'd3:  return !m_c;
            4'd4:  return m_n;
            4'd5:  return !m_n;
            4'd6:  return m_v;
            4'd7:  return !m_v;
            4'd8:  return m_c && !m_z;
            4'd9:  return !m_c || m_z;
            4'd10: return m_n == m_v;
            4'd11: return m_n != m_v;
            4'd12: return !m_z && (m_n == m_v);
            4'd13: return m_z || (m_n != m_v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] model_flags();
        return {m_n, m_z, m_c, m_v};
    endfunction

    // Advance one clock edge and update the model from the inputs applied
    task automatic tick();
        bit go, ce;
        go = (Valid === 1'b1) && (Stall === 1'b0) && (Reset_n === 1'b1);
        ce = model_cond(Cond);
        @(posedge CLK);
        if (Reset_n === 1'b0) begin
            {m_n, m_z, m_c, m_v} = 4'b0000;
            m_exec   = 0;
            m_squash = 0;
        end else begin
            if (go && ce) begin
                if (FlagW[1]) {m_n, m_z} = ALUFlags[3:2];
                if (FlagW[0]) {m_c, m_v} = ALUFlags[1:0];
            end
            if (CntClr) begin
                m_exec   = 0;
                m_squash = 0;
            end else if (go) begin
                if (ce) m_exec = (m_exec + 1) % CNT_MOD;
                else    m_squash = (m_squash + 1) % CNT_MOD;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        Valid = 1'b0; Stall = 1'b0; Cond = 4'he; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; CntClr = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        #1;
    endtask

    // Load the flag register through an always-executed write
    task automatic load_flags(logic [3:0] f);
        idle_inputs();
        Valid = 1'b1; Cond = 4'he; FlagW = 2'b11; ALUFlags = f;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset_n = 1'b0;
        Valid = 1'b1; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; Cond = 4'he;
        #1;
        total++;
        if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin
            bad++;
            $display("FAIL reset_gate: got %b expected 000", {PCSrc, RegWrite, MemWrite});
        end
        total++;
        if (CondEx !== 1'b1) begin
            bad++;
            $display("FAIL reset_condex: got %b expected 1", CondEx);
        end
        tick();
        total++;
        if ({Flags, ExecCount, SquashCount} !== {model_flags(), 4'(m_exec), 4'(m_squash)}) begin
            bad++;
            $display("FAIL reset_state: got flags=%b exec=%0d squash=%0d expected flags=%b exec=%0d squash=%0d",
                     Flags, ExecCount, SquashCount, model_flags(), m_exec, m_squash);
        end
        Reset_n = 1'b1;
        idle_inputs();
        #1;
    endtask

    task automatic test_basic();
        apply_reset();
        Valid = 1'b1; Cond = 4'he; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
        #1;
        total++;
        if ({CondEx, PCSrc, RegWrite, MemWrite} !== 4'b1111) begin
            bad++;
            $display("FAIL basic_enables: got %b expected 1111", {CondEx, PCSrc, RegWrite, MemWrite});
        end
        tick();
        total++;
        if (Flags !== model_flags() || ExecCount !== 4'(m_exec) || m_exec != 1) begin
            bad++;
            $display("FAIL basic_after: got flags=%b exec=%0d expected flags=%b exec=1",
                     Flags, ExecCount, model_flags());
        end
        idle_inputs();
    endtask

    task automatic test_flag_split();
        apply_reset();
        Valid = 1'b1; Cond = 4'he; FlagW = 2'b11; ALUFlags = 4'b0100;
        #1;
        total++;
        if (Flags !== 4'b0000) begin
            bad++;
            $display("FAIL split_no_forward: got %b expected 0000", Flags);
        end
        tick();
        total++;
        if (Flags !== model_flags()) begin
            bad++;
            $display("FAIL split_flags: got %b expected %b", Flags, model_flags());
        end
        FlagW = 2'b00; ALUFlags = 4'b0000; RegW = 1'b1; Cond = 4'b0000;
        #1;
        total++;
        if (RegWrite !== 1'b1) begin
            bad++;
            $display("FAIL split_eq_regwrite: got %b expected 1", RegWrite);
        end
        Cond = 4'b0001;
        #1;
        total++;
        if (RegWrite !== 1'b0) begin
            bad++;
            $display("FAIL split_ne_regwrite: got %b expected 0", RegWrite);
        end
        Cond = 4'b0000; NoWrite = 1'b1;
        #1;
        total++;
        if (RegWrite !== 1'b0) begin
            bad++;
            $display("FAIL split_nowrite: got %b expected 0", RegWrite);
        end
        idle_inputs();
    endtask

    task automatic test_squash();
        int sq_before;
        apply_reset();
        sq_before = m_squash;
        Valid = 1'b1; Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1011; MemW = 1'b1;
        #1;
        total++;
        if ({CondEx, MemWrite} !== 2'b00) begin
            bad++;
            $display("FAIL squash_comb: got condex=%b memwrite=%b expected 0 0", CondEx, MemWrite);
        end
        tick();
        total++;
        if (Flags !== 4'b0000 || SquashCount !== 4'((sq_before + 1) % CNT_MOD)) begin
            bad++;
            $display("FAIL squash_state: got flags=%b squash=%0d expected flags=0000 squash=%0d",
                     Flags, SquashCount, (sq_before + 1) % CNT_MOD);
        end
        idle_inputs();
    endtask

    task automatic test_partial();
        apply_reset();
        load_flags(4'b1100);
        Valid = 1'b1; Cond = 4'he; FlagW = 2'b01; ALUFlags = 4'b0011;
        tick();
        total++;
        if (Flags !== 4'b1111 || C_out !== 1'b1 || Flags !== model_flags()) begin
            bad++;
            $display("FAIL partial_write: got flags=%b c_out=%b expected flags=1111 c_out=1", Flags, C_out);
        end
        Valid = 1'b1; Cond = 4'he; FlagW = 2'b10; ALUFlags = 4'b0000;
        tick();
        total++;
        if (Flags !== model_flags() || C_out !== m_c) begin
            bad++;
            $display("FAIL partial_nz_only: got flags=%b c_out=%b expected flags=%b c_out=%b",
                     Flags, C_out, model_flags(), m_c);
        end
        idle_inputs();
    endtask

    task automatic test_sweep();
        int errs;
        errs = 0;
        apply_reset();
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c);
                #1;
                total++;
                if (CondEx !== model_cond(4'(c))) begin
                    bad++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL sweep cond=%h flags=%b: got %b expected %b",
                                 c, model_flags(), CondEx, model_cond(4'(c)));
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        logic [3:0] f0;
        int e0, s0;
        apply_reset();
        load_flags(4'b0110);
        f0 = model_flags(); e0 = m_exec; s0 = m_squash;
        for (int i = 0; i < 3; i++) begin
            Valid = 1'b1; Stall = 1'b1; Cond = 4'he; FlagW = 2'b11;
            ALUFlags = 4'($urandom_range(0, 15)); PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
            #1;
            total++;
            if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin
                bad++;
                $display("FAIL stall_gate: got %b expected 000", {PCSrc, RegWrite, MemWrite});
            end
            tick();
        end
        total++;
        if (Flags !== f0 || ExecCount !== 4'(e0) || SquashCount !== 4'(s0)) begin
            bad++;
            $display("FAIL stall_hold: got flags=%b exec=%0d squash=%0d expected flags=%b exec=%0d squash=%0d",
                     Flags, ExecCount, SquashCount, f0, e0, s0);
        end
        idle_inputs();
        Valid = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1001; MemW = 1'b1;
        #1;
        total++;
        if (MemWrite !== 1'b0) begin
            bad++;
            $display("FAIL invalid_gate: got %b expected 0", MemWrite);
        end
        tick();
        total++;
        if (Flags !== f0 || ExecCount !== 4'(e0)) begin
            bad++;
            $display("FAIL invalid_hold: got flags=%b exec=%0d expected flags=%b exec=%0d",
                     Flags, ExecCount, f0, e0);
        end
        idle_inputs();
    endtask

    task automatic test_cntclr();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            Valid = 1'b1; Cond = 4'he;
            tick();
        end
        Valid = 1'b1; Cond = 4'he; CntClr = 1'b1;
        tick();
        total++;
        if (ExecCount !== 4'd0 || ExecCount !== 4'(m_exec)) begin
            bad++;
            $display("FAIL cntclr_priority: got exec=%0d expected 0", ExecCount);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        apply_reset();
        CntClr = 1'b1;
        tick();
        CntClr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            Valid = 1'b1; Cond = 4'he;
            tick();
            total++;
            if (ExecCount !== 4'(m_exec)) begin
                bad++;
                $display("FAIL wrap step %0d: got exec=%0d expected %0d", i, ExecCount, m_exec);
            end
        end
        total++;
        if (ExecCount !== 4'd0) begin
            bad++;
            $display("FAIL wrap_final: got exec=%0d expected 0", ExecCount);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        load_flags(4'b1010);
        Valid = 1'b1; Cond = 4'b0000;
        tick();
        Reset_n = 1'b0; Valid = 1'b1; Cond = 4'he; FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        total++;
        if (Flags !== 4'b0000 || ExecCount !== 4'd0 || SquashCount !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid: got flags=%b exec=%0d squash=%0d expected 0000 0 0",
                     Flags, ExecCount, SquashCount);
        end
        Reset_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_random();
        int errs;
        bit go, ce;
        errs = 0;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            Reset_n  = ($urandom_range(0, 29) != 0);
            Valid    = ($urandom_range(0, 3) != 0);
            Stall    = ($urandom_range(0, 4) == 0);
            Cond     = 4'($urandom_range(0, 15));
            ALUFlags = 4'($urandom_range(0, 15));
            FlagW    = 2'($urandom_range(0, 3));
            PCS      = 1'($urandom_range(0, 1));
            RegW     = 1'($urandom_range(0, 1));
            MemW     = 1'($urandom_range(0, 1));
            NoWrite  = 1'($urandom_range(0, 1));
            CntClr   = ($urandom_range(0, 19) == 0);
            #1;
            go = Valid && !Stall && Reset_n;
            ce = model_cond(Cond);
            total++;
            if ({CondEx, PCSrc, RegWrite, MemWrite} !==
                {ce, PCS && ce && go, RegW && !NoWrite && ce && go, MemW && ce && go}) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_comb cycle %0d: got %b expected %b", i,
                             {CondEx, PCSrc, RegWrite, MemWrite},
                             {ce, PCS && ce && go, RegW && !NoWrite && ce && go, MemW && ce && go});
            end
            tick();
            total++;
            if (Flags !== model_flags() || C_out !== m_c ||
                ExecCount !== 4'(m_exec) || SquashCount !== 4'(m_squash)) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_state cycle %0d: got flags=%b exec=%0d squash=%0d expected flags=%b exec=%0d squash=%0d",
                             i, Flags, ExecCount, SquashCount, model_flags(), m_exec, m_squash);
            end
        end
        Reset_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        Reset_n = 1'b0;
        idle_inputs();
        {m_n, m_z, m_c, m_v} = 4'b0000;
        m_exec = 0;
        m_squash = 0;
        #2;
        test_reset();
        test_basic();
        test_flag_split();
        test_squash();
        test_partial();
        test_sweep();
        test_stall();
        test_cntclr();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer end of the ALU flag interface.
- Holds the architectural NZCV register and evaluates each instruction's 4-bit ARM condition field against it.
- Gates the instruction's PC, register and memory write enables, and feeds the registered carry back to the ALU carry-in for ADC/SBC/RSC.
- Keeps executed and squashed instruction counters for performance measurement.

Parameters:
CNT_W, 32, width of the ExecCount and SquashCount counters.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
Reset_n  input  1  synchronous, active-low reset.
Valid  input  1  an instruction is present this cycle.
Stall  input  1  pipeline hold: no state update this cycle.
Cond  input  4  instruction condition field.
ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
FlagW  input  2  [1] = write N,Z; [0] = write C,V.
PCS  input  1  instruction writes the PC.
RegW  input  1  instruction writes a register.
MemW  input  1  instruction writes memory.
NoWrite  input  1  compare/test class instruction; suppresses the register write.
CntClr  input  1  synchronous clear of both counters.
CondEx  output  1  condition passed.
PCSrc  output  1  gated PC write.
RegWrite  output  1  gated register write.
MemWrite  output  1  gated memory write.
Flags  output  4  registered {N,Z,C,V}.
C_out  output  1  Flags[1]; drives the ALU C_in.
ExecCount  output  CNT_W  number of instructions that passed their condition.
SquashCount  output  CNT_W  number of instructions that failed their condition.

Behaviour:
- Reset (Reset_n low at a rising edge): Flags=4'b0000, ExecCount=0, SquashCount=0.
- While Reset_n is low, PCSrc, RegWrite and MemWrite are forced to 0. CondEx is still evaluated.
- CondEx is combinational from Cond and the registered Flags (never from ALUFlags), zero latency:
  - 0000 EQ: Z.  0001 NE: !Z.
  - 0010 CS: C.  0011 CC: !C.
  - 0100 MI: N.  0101 PL: !N.
  - 0110 VS: V.  0111 VC: !V.
  - 1000 HI: C&!Z.  1001 LS: !C|Z.
  - 1010 GE: N==V.  1011 LT: N!=V.
  - 1100 GT: !Z&(N==V).  1101 LE: Z|(N!=V).
  - 1110 AL: 1.  1111 NV: 0.
- Update enable: Go = Valid & ~Stall & Reset_n.
- Gated outputs, combinational:
  - PCSrc = PCS & CondEx & Go.
  - RegWrite = RegW & ~NoWrite & CondEx & Go.
  - MemWrite = MemW & CondEx & Go.
- Flag update at the clock edge when Go & CondEx:
  - FlagW[1]: N,Z <= ALUFlags[3:2].
  - FlagW[0]: C,V <= ALUFlags[1:0].
  - Each pair is independent; unselected bits hold.
- A failed condition never writes flags, even with FlagW set.
- The new flags are visible to the next instruction one cycle later. There is no same-cycle forwarding.
- C_out = Flags[1], registered; it changes only at a flag-updating edge.
- Counters, wrap modulo 2^CNT_W:
  - Go & CondEx: ExecCount+1.
  - Go & ~CondEx: SquashCount+1.
  - CntClr has priority over the increment in the same cycle. Clear-and-increment leaves the counter at 0.
- Stall=1: flags and counters hold; PCSrc, RegWrite and MemWrite are 0.
- Valid=0: same as Stall.
- Reset asserted mid-stream overrides Go, flag writes and counter updates in that cycle.

Test Plan:
- Reset, then Cond=1110 with PCS=RegW=MemW=1 and Valid=1 -> CondEx=1, all three write enables=1, Flags=0000, ExecCount=1 after the edge.
- Flag write and condition split:
  - Cycle 1: Cond=1110, FlagW=11, ALUFlags=0100 -> Flags=0100 after the edge.
  - Cycle 2: Cond=0000 (EQ) with RegW=1 -> RegWrite=1. In the same cycle Cond=0001 (NE) would give RegWrite=0.
- Squash with FlagW=11 and ALUFlags=1011 while Flags=0000 and Cond=0000 -> CondEx=0, Flags stay 0000, SquashCount+1, MemWrite=0.
- Partial write: Flags=1100, FlagW=01, ALUFlags=0011, Cond=AL -> Flags=1111 and C_out=1 next cycle.
- Sweep all 16 Cond values against all 16 Flags values (256 cases) -> CondEx matches the condition table, and NV is 0 in every case.
- Counter boundaries:
  - Stall=1 with Valid=1 for 3 cycles -> counters and flags unchanged.
  - CntClr together with a passing instruction -> ExecCount=0.
  - With CNT_W=4, 16 passing instructions from a cleared counter -> ExecCount wraps to 0.
  - Reset_n low mid-sequence -> all state cleared at that edge.
